// File: rtl/l1_set_way_ctrl.sv
// l1_set_way_ctrl
// Way-selection controller for one set of the 8-way L1 cache. It holds the
// tag/valid/dirty state for the set and resolves each request as a hit or a
// miss. On a miss it picks a victim (the lowest-index invalid way, otherwise
// the LRU eviction way), runs the writeback and fill handshakes, and then
// reports the resolved way. Every accepted request produces exactly one LRU
// access pulse.
//
// Optional feature: define STATS_CNT_EN to add saturating hit/miss counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake; ready only in IDLE
//   req_tag, req_write  request tag and read/write flag
//   resp_valid          one-cycle completion pulse
//   resp_hit, resp_way  hit flag and the way now holding the tag
//   lru_evict_way       eviction candidate from the LRU, sampled in LOOKUP
//   lru_access_valid    one-cycle LRU update pulse
//   lru_access_way      way reported to the LRU
//   wb_valid/ready      writeback handshake for a dirty victim
//   wb_tag              tag of the victim being written back
//   fill_valid/ready    line-fill handshake
//   fill_tag            tag being filled
//   hit_cnt, miss_cnt   saturating statistics (STATS_CNT_EN only)

module l1_set_way_ctrl #(
  parameter int unsigned TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_write,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [2:0]       resp_way,
  input  logic [2:0]       lru_evict_way,
  output logic [2:0]       lru_access_way,
  output logic             lru_access_valid,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic             fill_valid,
  input  logic             fill_ready,
  output logic [TAG_W-1:0] fill_tag
`ifdef STATS_CNT_EN
  ,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
`endif
);

  localparam int unsigned NUM_WAYS = 8;
  localparam int unsigned WAY_W    = 3;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  state_t                state;
  logic [TAG_W-1:0]      tag_q [NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_q;
  logic [NUM_WAYS-1:0]   dirty_q;
  logic [TAG_W-1:0]      r_tag;
  logic                  r_write;
  logic [WAY_W-1:0]      r_way;

  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic                  has_inv;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      victim;

  // Tag match and victim choice; the lowest index wins in both searches.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int i = 0; i < int'(NUM_WAYS); i++) begin
      if (!hit && valid_q[i] && (tag_q[i] == r_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!has_inv && !valid_q[i]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(i);
      end
    end
    victim = has_inv ? inv_way : lru_evict_way;
  end

  // Controller FSM; outputs are registered alongside each state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      valid_q          <= '0;
      dirty_q          <= '0;
      r_tag            <= '0;
      r_write          <= 1'b0;
      r_way            <= '0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_way         <= '0;
      lru_access_valid <= 1'b0;
      lru_access_way   <= '0;
      wb_valid         <= 1'b0;
      wb_tag           <= '0;
      fill_valid       <= 1'b0;
      fill_tag         <= '0;
    end else begin
      resp_valid       <= 1'b0;
      lru_access_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_tag     <= req_tag;
            r_write   <= req_write;
            req_ready <= 1'b0;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            r_way            <= hit_way;
            resp_valid       <= 1'b1;
            resp_hit         <= 1'b1;
            resp_way         <= hit_way;
            lru_access_valid <= 1'b1;
            lru_access_way   <= hit_way;
            state            <= S_RESP;
          end else begin
            r_way <= victim;
            if (valid_q[victim] && dirty_q[victim]) begin
              wb_valid <= 1'b1;
              wb_tag   <= tag_q[victim];
              state    <= S_WB;
            end else begin
              fill_valid <= 1'b1;
              fill_tag   <= r_tag;
              state      <= S_FILL;
            end
          end
        end
        S_WB: begin
          if (wb_ready) begin
            dirty_q[r_way] <= 1'b0;
            wb_valid       <= 1'b0;
            fill_valid     <= 1'b1;
            fill_tag       <= r_tag;
            state          <= S_FILL;
          end
        end
        S_FILL: begin
          if (fill_ready) begin
            tag_q[r_way]     <= r_tag;
            valid_q[r_way]   <= 1'b1;
            dirty_q[r_way]   <= 1'b0;
            fill_valid       <= 1'b0;
            resp_valid       <= 1'b1;
            resp_hit         <= 1'b0;
            resp_way         <= r_way;
            lru_access_valid <= 1'b1;
            lru_access_way   <= r_way;
            state            <= S_RESP;
          end
        end
        S_RESP: begin
          // Write-allocate, write-back: a write leaves the line dirty.
          if (r_write) begin
            dirty_q[r_way] <= 1'b1;
          end
          resp_hit  <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef STATS_CNT_EN
  // Saturating hit/miss counters, bumped once per completed request.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_RESP) begin
      if (resp_hit) begin
        if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_l1_set_way_ctrl.sv
// Scoreboard bench for l1_set_way_ctrl: a behavioural set model predicts
// responses, writebacks and fills; a monitor compares whatever the DUT presents.
module tb_l1_set_way_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_tag;
  logic        req_write;
  logic        resp_valid;
  logic        resp_hit;
  logic [2:0]  resp_way;
  logic [2:0]  lru_evict_way;
  logic [2:0]  lru_access_way;
  logic        lru_access_valid;
  logic        wb_valid;
  logic        wb_ready;
  logic [11:0] wb_tag;
  logic        fill_valid;
  logic        fill_ready;
  logic [11:0] fill_tag;
`ifdef STATS_CNT_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  l1_set_way_ctrl #(.TAG_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_write(req_write),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .lru_evict_way(lru_evict_way), .lru_access_way(lru_access_way),
    .lru_access_valid(lru_access_valid),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_tag(fill_tag)
`ifdef STATS_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model of the set
  logic [11:0] mtag [8];
  bit          mvalid [8];
  bit          mdirty [8];
  int          mhits, mmiss;

  // Scoreboard queues
  bit          exp_hit_q [$];
  logic [2:0]  exp_way_q [$];
  logic [11:0] exp_wb_q [$];
  logic [11:0] exp_fill_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 0;
      mdirty[i] = 0;
    end
    mhits = 0;
    mmiss = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Present a request and return just after the accepting edge.
  task automatic issue(input logic [11:0] t, input logic w, input logic [2:0] ev);
    int k;
    @(negedge clk);
    req_valid     = 1'b1;
    req_tag       = t;
    req_write     = w;
    lru_evict_way = ev;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Model the request, queue expectations, drive it and wait for the response.
  task automatic do_req(input logic [11:0] t, input logic w, input logic [2:0] ev,
                        input int wb_stall, input bit rnd_rdy, input bit chk_lat);
    bit         hit;
    bit         dirty_vic;
    bit         found_inv;
    logic [2:0] way;
    int         lat, n, wbcnt;
    bit         done;
    hit = 0; way = 3'd0; dirty_vic = 0; found_inv = 0;
    for (int i = 0; i < 8; i++)
      if (!hit && mvalid[i] && mtag[i] == t) begin hit = 1; way = 3'(i); end
    if (!hit) begin
      for (int i = 0; i < 8; i++)
        if (!found_inv && !mvalid[i]) begin found_inv = 1; way = 3'(i); end
      if (!found_inv) way = ev;
      if (mvalid[way] && mdirty[way]) begin
        dirty_vic = 1;
        exp_wb_q.push_back(mtag[way]);
      end
      exp_fill_q.push_back(t);
      mtag[way]   = t;
      mvalid[way] = 1;
      mdirty[way] = 0;
    end
    if (w) mdirty[way] = 1;
    if (hit) begin if (mhits < 65535) mhits++; end
    else begin if (mmiss < 65535) mmiss++; end
    exp_hit_q.push_back(hit);
    exp_way_q.push_back(way);
    lat = hit ? 2 : (dirty_vic ? 4 + wb_stall : 3);

    wb_ready   = (wb_stall == 0);
    fill_ready = 1'b1;
    issue(t, w, ev);
    n = 0; wbcnt = 0; done = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (resp_valid) done = 1;
      if (rnd_rdy) begin
        wb_ready   = 1'($urandom_range(0, 1));
        fill_ready = 1'($urandom_range(0, 1));
      end else if (wb_valid && !wb_ready) begin
        wbcnt++;
        if (wbcnt > wb_stall) wb_ready = 1'b1;
      end
    end
    if (!done) chk("resp_timeout", 0, 1);
    else if (chk_lat) chk("latency", n + 1, lat);
    wb_ready   = 1'b1;
    fill_ready = 1'b1;
  endtask

  // Monitor: compares presented outputs against queued expectations.
  initial begin
    bit          pwb, pfill;
    logic [11:0] pwb_tag, pfill_tag;
    pwb = 0; pfill = 0; pwb_tag = '0; pfill_tag = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pwb = 0;
        pfill = 0;
      end else begin
        if (resp_valid) begin
          if (exp_hit_q.size() == 0) chk("unexpected_resp", 1, 0);
          else begin
            bit         eh;
            logic [2:0] ew;
            eh = exp_hit_q.pop_front();
            ew = exp_way_q.pop_front();
            chk("resp_hit", resp_hit, eh);
            chk("resp_way", resp_way, ew);
            chk("lru_access_valid", lru_access_valid, 1);
            chk("lru_access_way", lru_access_way, ew);
          end
        end else if (lru_access_valid) chk("lru_pulse_without_resp", 1, 0);
        if (pwb) begin
          chk("wb_hold_valid", wb_valid, 1);
          chk("wb_hold_tag", wb_tag, pwb_tag);
        end
        if (pfill) begin
          chk("fill_hold_valid", fill_valid, 1);
          chk("fill_hold_tag", fill_tag, pfill_tag);
        end
        if (wb_valid && wb_ready) begin
          if (exp_wb_q.size() == 0) chk("unexpected_wb", 1, 0);
          else chk("wb_tag", wb_tag, exp_wb_q.pop_front());
        end
        if (fill_valid && fill_ready) begin
          if (exp_fill_q.size() == 0) chk("unexpected_fill", 1, 0);
          else chk("fill_tag", fill_tag, exp_fill_q.pop_front());
        end
        pwb       = wb_valid && !wb_ready;
        pwb_tag   = wb_tag;
        pfill     = fill_valid && !fill_ready;
        pfill_tag = fill_tag;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; req_valid = 1'b0; req_tag = '0; req_write = 1'b0;
    lru_evict_way = '0; wb_ready = 1'b1; fill_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_lru_access_valid", lru_access_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fill_valid", fill_valid, 0);

    // Cold miss into way 0, then a hit on the same tag
    do_req(12'h123, 1'b0, 3'd5, 0, 0, 1);
    do_req(12'h123, 1'b0, 3'd5, 0, 0, 1);

    // Fill all ways, dirty way 3, evict it through the LRU way
    do_reset();
    for (int i = 0; i < 8; i++) do_req(12'(12'h100 + i), 1'b0, 3'd0, 0, 0, 1);
    do_req(12'h103, 1'b1, 3'd0, 0, 0, 1);
    do_req(12'h200, 1'b0, 3'd3, 0, 0, 1);
    // Dirty eviction with a five-cycle writeback stall
    do_req(12'h200, 1'b1, 3'd0, 0, 0, 1);
    do_req(12'h300, 1'b0, 3'd3, 5, 0, 1);
    // All ways valid: LRU way is used even when clean
    do_req(12'h400, 1'b0, 3'd5, 0, 0, 1);

    // Randomized traffic with random handshake back-pressure
    for (int r = 0; r < 300; r++) begin
      logic [11:0] t;
      t = ($urandom_range(0, 19) == 0) ? 12'($urandom_range(0, 4095))
                                       : 12'(12'h100 + $urandom_range(0, 11));
      do_req(t, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0, 1, 0);
    end

    // Reset while a fill is outstanding
    do_reset();
    for (int i = 0; i < 3; i++) do_req(12'(12'h100 + i), 1'b1, 3'd0, 0, 0, 1);
    fill_ready = 1'b0;
    issue(12'h7FF, 1'b0, 3'd0);
    k = 0;
    while (!fill_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("abort_fill_seen", fill_valid, 1);
    chk("abort_fill_tag", fill_tag, 12'h7FF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_fill_dropped", fill_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    rst = 1'b0;
    model_reset();
    fill_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("abort_no_resp", resp_valid, 0);
      chk("abort_no_lru", lru_access_valid, 0);
    end
    do_req(12'h101, 1'b0, 3'd6, 0, 0, 1);
    do_req(12'h101, 1'b0, 3'd6, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_drained", exp_hit_q.size(), 0);
    chk("wb_queue_drained", exp_wb_q.size(), 0);
    chk("fill_queue_drained", exp_fill_q.size(), 0);
`ifdef STATS_CNT_EN
    chk("hit_cnt", hit_cnt, mhits);
    chk("miss_cnt", miss_cnt, mmiss);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
